scan_driver: RTL and testbench
==============================

Name: scan_driver

Overview:
- Time-multiplexes up to 8 hex/BCD digits onto a common-anode seven-segment bank.
- Generates the 3-bit digit index and active-low enable that feed the downstream 3-to-8 digit-select decoder (`a`, `nEn`).
- Generates the shared active-low segment bus.
- Sits between the clock/time-keeping counters, which supply digit values, and the digit-select decoder plus the board segment pins.

Parameters:
- DIV, 50000, clk cycles per digit slot; legal range 2..65535.
- BLANK_CYC, 500, cycles at the start of each slot with all digits off (anti-ghosting); must be < DIV.
- NDIG, 8, number of digits scanned; legal range 1..8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- nRst  input  1  synchronous active-low reset.
- en  input  1  scan enable; low blanks the display and parks the scanner.
- digits  input  32  digit values; digit i in digits[4i+3:4i]; digit 0 is rightmost.
- dp  input  8  decimal point request per digit, active-high.
- blank  input  8  per-digit blank request, active-high.
- sel  output  3  digit index to decoder `a`.
- sel_n_en  output  1  to decoder `nEn`; 1 = all digits off.
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
- frame_start  output  1  one-cycle pulse when slot 0 begins.

Behaviour:
- Reset value of every output (nRst low at a clock edge): sel=0, sel_n_en=1, seg=8'hFF, frame_start=0.
- Reset value of internal state: cnt=0, slot=0, shadow registers loaded from the live inputs.
- Reset has priority over en and takes effect mid-slot or mid-frame with no residue.
- Internal state:
  - cnt: 0..DIV-1, ceil(log2 DIV) bits.
  - slot: 0..NDIG-1.
  - shadow copies of digits, dp and blank.
- Counting when en=1:
  - cnt increments each cycle.
  - At cnt=DIV-1, cnt goes to 0 and slot advances.
  - At slot=NDIG-1 the advance wraps slot to 0; no out-of-range slot is ever produced.
- Counting when en=0: cnt and slot are held at 0.
  - Re-asserting en always starts at slot 0, cnt 0, so a frame begins exactly on the en rise.
- Shadow registers:
  - Loaded from the live inputs on every cycle with en=0.
  - Loaded on the last cycle of a frame (slot=NDIG-1, cnt=DIV-1).
  - Otherwise held, so input changes mid-frame never tear the display.
- Outputs are registered, 1-cycle latency from internal state (cycle n state drives cycle n+1 outputs):
  - sel <= slot.
  - sel_n_en <= ~(en & (cnt >= BLANK_CYC) & ~shadow_blank[slot]).
  - seg <= sel_n_en_next ? 8'hFF : {~shadow_dp[slot], glyph(shadow_digit[slot])}.
  - frame_start <= en & (slot==0) & (cnt==0).
- Glyph table, active-low {g..a} shown as full byte with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - dp set clears bit 7.
- Phases within a slot:
  - BLANK phase: cnt < BLANK_CYC.
  - SHOW phase: cnt >= BLANK_CYC.
  - When BLANK_CYC=0 there is no BLANK phase; sel_n_en deasserts on the first output cycle of the slot.
- A blanked digit stays dark for its whole slot, but its slot time is still consumed, so refresh rate is constant.
- en falling mid-slot: on the next output cycle sel_n_en=1, seg=FF and sel=0; no partial glyph is emitted.
- frame_start is never asserted while en=0 or while nRst=0.
- Timing constants:
  - Frame period is exactly NDIG*DIV cycles.
  - Display duty per digit is (DIV-BLANK_CYC)/(NDIG*DIV).

Test Plan:
- Reset behaviour: DIV=4, BLANK_CYC=1, NDIG=8, nRst low 3 cycles then high, en=0 → sel=0, sel_n_en=1, seg=FF, frame_start=0 throughout.
- Full scan sequence: same parameters, digits=32'h76543210, dp=0, blank=0, en rises.
  - frame_start pulses 1 cycle after the en rise.
  - Per 4-cycle slot: 1 cycle of sel_n_en=1/seg=FF, then 3 cycles of sel_n_en=0.
  - Sequence is sel=0/seg=C0, sel=1/F9, sel=2/A4, … sel=7/F8, then wraps to sel=0.
  - frame_start repeats every 32 cycles.
- Decimal point, blanking and hex glyphs: dp=8'h04, blank=8'h80, digits=32'hFEDCBA98.
  - Slot 2 shows seg=08 (88 with dp cleared).
  - Slot 7 keeps sel_n_en=1 and seg=FF for all 4 cycles.
  - Slot 0 shows 80.
- No tearing: digits change from 32'h0 to 32'h11111111 during slot 3.
  - Slots 3..7 of the current frame still show C0.
  - The next frame shows F9 in every slot.
- Enable and reset mid-operation:
  - en dropped in slot 5: next output cycle gives sel=0, sel_n_en=1, seg=FF; on en re-rise the scan restarts at slot 0 with a frame_start pulse.
  - nRst pulsed low in slot 4: outputs return to their reset values on the following cycle.
- Short chain: NDIG=6, DIV=2, BLANK_CYC=0 → sel cycles 0..5 and wraps to 0, never 6 or 7; sel_n_en is held 0 continuously while en=1; frame period is 12 cycles.

Source files
------------

// File: rtl/scan_driver.sv
// Seven-segment scan driver: time-multiplexes up to 8 digits onto a
// common-anode bank with per-slot anti-ghost blanking.
module scan_driver #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 500,
    parameter int NDIG      = 8
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        en,
    input  logic [31:0] digits,
    input  logic [7:0]  dp,
    input  logic [7:0]  blank,
    output logic [2:0]  sel,
    output logic        sel_n_en,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [2:0] SLOT_MAX = 3'(NDIG - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    slot_q, slot_d;
    logic [31:0]   sh_digits_q, sh_digits_d;
    logic [7:0]    sh_dp_q, sh_dp_d;
    logic [7:0]    sh_blank_q, sh_blank_d;
    logic [2:0]    sel_q, sel_d;
    logic          sel_n_en_q, sel_n_en_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_start_q, frame_start_d;

    logic          in_show;
    logic          last_cyc;
    logic [3:0]    cur_digit;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // With no blanking window every cycle of the slot is display time.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_show = 1'b1;
        end else begin : g_blank
            assign in_show = (cnt_q >= CW'(BLANK_CYC));
        end
    endgenerate

    assign last_cyc  = (slot_q == SLOT_MAX) && (cnt_q == CNT_MAX);
    assign cur_digit = sh_digits_q[{slot_q, 2'b00} +: 4];

    always_comb begin
        cnt_d         = cnt_q;
        slot_d        = slot_q;
        sh_digits_d   = sh_digits_q;
        sh_dp_d       = sh_dp_q;
        sh_blank_d    = sh_blank_q;
        sel_d         = 3'd0;
        sel_n_en_d    = 1'b1;
        seg_d         = 8'hFF;
        frame_start_d = 1'b0;

        if (!en) begin
            cnt_d  = '0;
            slot_d = 3'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            slot_d = (slot_q == SLOT_MAX) ? 3'd0 : slot_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Shadows only refresh between frames so a frame is never torn.
        if (!en || last_cyc) begin
            sh_digits_d = digits;
            sh_dp_d     = dp;
            sh_blank_d  = blank;
        end

        if (en) begin
            sel_d = slot_q;
        end
        sel_n_en_d    = ~(en & in_show & ~sh_blank_q[slot_q]);
        seg_d         = sel_n_en_d ? 8'hFF
                                   : {~sh_dp_q[slot_q], glyph(cur_digit)};
        frame_start_d = en && (slot_q == 3'd0) && (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            cnt_q         <= '0;
            slot_q        <= 3'd0;
            sh_digits_q   <= digits;
            sh_dp_q       <= dp;
            sh_blank_q    <= blank;
            sel_q         <= 3'd0;
            sel_n_en_q    <= 1'b1;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sel_q         <= sel_d;
            sel_n_en_q    <= sel_n_en_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sel         = sel_q;
    assign sel_n_en    = sel_n_en_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scan_driver.sv
// Bench for scan_driver: two instances (8-digit and short 6-digit chain)
// checked cycle by cycle against a frame-position scoreboard.
module tb_scan_driver;

    typedef struct packed {
        logic [2:0] sel;
        logic       nen;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam int DIVS [2] = '{4, 2};
    localparam int BCS  [2] = '{1, 0};
    localparam int NDS  [2] = '{8, 6};

    logic        clk = 1'b0;
    logic        nrst;
    logic        en8, en6;
    logic [31:0] digits;
    logic [7:0]  dp, blank;

    logic [2:0]  sel8, sel6;
    logic        nen8, nen6;
    logic [7:0]  seg8, seg6;
    logic        fs8, fs6;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t q0 [$];
    exp_t q1 [$];

    bit          run      [2];
    int          k        [2];
    logic [31:0] fd       [2];
    logic [7:0]  fdp      [2];
    logic [7:0]  fbl      [2];
    bit          fs_valid [2];
    int          last_fs  [2];
    logic [31:0] prev_dig;
    logic [7:0]  prev_dp, prev_bl;

    always #5 clk = ~clk;

    scan_driver #(.DIV(4), .BLANK_CYC(1), .NDIG(8)) u_dut8 (
        .clk         (clk),
        .nRst        (nrst),
        .en          (en8),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .sel         (sel8),
        .sel_n_en    (nen8),
        .seg         (seg8),
        .frame_start (fs8)
    );

    scan_driver #(.DIV(2), .BLANK_CYC(0), .NDIG(6)) u_dut6 (
        .clk         (clk),
        .nRst        (nrst),
        .en          (en6),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .sel         (sel6),
        .sel_n_en    (nen6),
        .seg         (seg6),
        .frame_start (fs6)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic exp_t model(input int d, input int kk);
        exp_t e;
        int   slot;
        int   c;
        logic [3:0] v;
        slot  = (kk / DIVS[d]) % NDS[d];
        c     = kk % DIVS[d];
        v     = fd[d][slot*4 +: 4];
        e.sel = 3'(slot);
        e.nen = (c < BCS[d]) || fbl[d][slot];
        e.seg = e.nen ? 8'hFF : {~fdp[d][slot], GLYPH[v]};
        e.fs  = ((kk % (DIVS[d] * NDS[d])) == 0);
        return e;
    endfunction

    task automatic compare(input int d, input exp_t e, input exp_t o);
        string p;
        p = (d == 0) ? "d8" : "d6";
        check({p, "_sel"}, 32'(o.sel), 32'(e.sel));
        check({p, "_nen"}, 32'(o.nen), 32'(e.nen));
        check({p, "_seg"}, 32'(o.seg), 32'(e.seg));
        check({p, "_fs"},  32'(o.fs),  32'(e.fs));
        if (o.fs) begin
            if (fs_valid[d])
                check({p, "_period"}, 32'(cyc - last_fs[d]),
                      32'(DIVS[d] * NDS[d]));
            fs_valid[d] = 1'b1;
            last_fs[d]  = cyc;
        end
    endtask

    task automatic tick();
        logic en_v [2];
        exp_t e;
        exp_t o;
        en_v[0] = en8;
        en_v[1] = en6;
        for (int d = 0; d < 2; d++) begin
            if (!nrst || !en_v[d]) begin
                e           = '{3'd0, 1'b1, 8'hFF, 1'b0};
                run[d]      = 1'b0;
                fs_valid[d] = 1'b0;
            end else begin
                if (!run[d]) begin
                    k[d]   = 0;
                    run[d] = 1'b1;
                end
                if ((k[d] % (DIVS[d] * NDS[d])) == 0) begin
                    fd[d]  = prev_dig;
                    fdp[d] = prev_dp;
                    fbl[d] = prev_bl;
                end
                e = model(d, k[d]);
                k[d]++;
            end
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        prev_dig = digits;
        prev_dp  = dp;
        prev_bl  = blank;
        @(posedge clk);
        #1;
        cyc++;
        if (q0.size() == 0 || q1.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            o = '{sel8, nen8, seg8, fs8};
            compare(0, q0.pop_front(), o);
            o = '{sel6, nen6, seg6, fs6};
            compare(1, q1.pop_front(), o);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int pos);
        int n;
        n = 0;
        while ((k[0] % 32) != pos && n < 100) begin
            tick();
            n++;
        end
        check("run_to_bound", 32'(k[0] % 32), 32'(pos));
    endtask

    initial begin
        nrst   = 1'b0;
        en8    = 1'b0;
        en6    = 1'b0;
        digits = 32'h7654_3210;
        dp     = 8'h00;
        blank  = 8'h00;
        prev_dig = digits;
        prev_dp  = dp;
        prev_bl  = blank;
        for (int d = 0; d < 2; d++) begin
            run[d] = 1'b0;
            k[d] = 0;
            fs_valid[d] = 1'b0;
            last_fs[d] = 0;
        end
        #1;
        ticks(3);
        nrst = 1'b1;
        ticks(3);

        en8 = 1'b1;
        en6 = 1'b1;
        ticks(70);

        dp     = 8'h04;
        blank  = 8'h80;
        digits = 32'hFEDC_BA98;
        ticks(70);

        dp     = 8'h00;
        blank  = 8'h00;
        digits = 32'h0;
        en8    = 1'b0;
        tick();
        en8 = 1'b1;
        run_to(13);
        digits = 32'h1111_1111;
        ticks(50);

        run_to(21);
        en8 = 1'b0;
        ticks(2);
        en8 = 1'b1;
        ticks(12);

        run_to(17);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        ticks(40);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) digits = $urandom;
            if ($urandom_range(0, 9) == 0) dp = 8'($urandom);
            if ($urandom_range(0, 9) == 0) blank = 8'($urandom);
            if ($urandom_range(0, 60) == 0) en8 = ~en8;
            if ($urandom_range(0, 60) == 0) en6 = ~en6;
            nrst = ($urandom_range(0, 150) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
